// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the EX-stage forwarding/hazard unit.
// Used by fwd_src_select and fwd_hazard_unit.
package fwd_hazard_unit_pkg;

    localparam int FWD_SEL_RF            = 0;
    localparam int DEFAULT_STALL_TIMEOUT = 255;
    localparam int WD_W                  = 8;

    typedef enum logic [0:0] {
        STG_ME = 1'b0,
        STG_WB = 1'b1
    } fwd_stage_e;

    function automatic logic [WD_W-1:0] sat_inc8(input logic [WD_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Priority forwarding match for one source operand: youngest matching producer wins.
// Also produces this operand's stall term (producer data not ready, or scoreboard pending).
module fwd_src_select
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int ADDR_W     = 5,
    parameter int SEL_W      = 2
) (
    input  logic                         rs_ren,
    input  logic [ADDR_W-1:0]            rs_addr,
    input  logic [NUM_STAGES-1:0]        stg_rd_wena,
    input  logic [NUM_STAGES*ADDR_W-1:0] stg_rd_waddr,
    input  logic [NUM_STAGES-1:0]        stg_data_rdy,
    input  logic [2**ADDR_W-1:0]         sb_busy,
    output logic [SEL_W-1:0]             src_sel,
    output logic                         src_stall
);

    logic [NUM_STAGES-1:0] hit_s;
    logic                  fwd_rdy_s;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_hit
        assign hit_s[k] = rs_ren & stg_rd_wena[k]
                        & (stg_rd_waddr[k*ADDR_W +: ADDR_W] != '0)
                        & (stg_rd_waddr[k*ADDR_W +: ADDR_W] == rs_addr);
    end

    // Walk oldest to youngest so the lowest matching index overrides.
    always_comb begin
        src_sel   = SEL_W'(FWD_SEL_RF);
        fwd_rdy_s = 1'b1;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            src_sel   = hit_s[k] ? SEL_W'(k + 1) : src_sel;
            fwd_rdy_s = hit_s[k] ? stg_data_rdy[k] : fwd_rdy_s;
        end
    end

    assign src_stall = ((|hit_s) & ~fwd_rdy_s) | (rs_ren & sb_busy[rs_addr]);

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use/scoreboard stall and stall watchdog.
// Optional FWD_PERF_CNT_EN adds stall-cycle and forwarded-instruction counters.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int NUM_STAGES    = 2,
    parameter int ADDR_W        = 5,
    parameter int STALL_TIMEOUT = DEFAULT_STALL_TIMEOUT,
    localparam int SEL_W        = $clog2(NUM_STAGES + 1),
    localparam int NREG         = 2**ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex_valid,
    input  logic [NUM_SRC-1:0]           ex_rs_ren,
    input  logic [NUM_SRC*ADDR_W-1:0]    ex_rs_addr,
    input  logic [NUM_STAGES-1:0]        stg_rd_wena,
    input  logic [NUM_STAGES*ADDR_W-1:0] stg_rd_waddr,
    input  logic [NUM_STAGES-1:0]        stg_data_rdy,
    input  logic                         lat_issue,
    input  logic [ADDR_W-1:0]            lat_issue_rd,
    input  logic                         lat_done,
    input  logic [ADDR_W-1:0]            lat_done_rd,
    input  logic                         flush,
    output logic [NUM_SRC*SEL_W-1:0]     src_sel,
    output logic                         stall,
    output logic [NREG-1:0]              sb_busy,
    output logic                         hazard_timeout
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_fwd_cnt
`endif
);

    localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

    logic [NUM_SRC-1:0] src_stall_s;
    logic               fire_s;
    logic [NREG-1:0]    set_mask_s;
    logic [NREG-1:0]    clr_mask_s;

    logic [NREG-1:0]    sb_busy_d,        sb_busy_q;
    logic [WD_W-1:0]    stall_run_d,      stall_run_q;
    logic               hazard_timeout_d, hazard_timeout_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_select #(
            .NUM_STAGES (NUM_STAGES),
            .ADDR_W     (ADDR_W),
            .SEL_W      (SEL_W)
        ) u_sel (
            .rs_ren       (ex_rs_ren[i]),
            .rs_addr      (ex_rs_addr[i*ADDR_W +: ADDR_W]),
            .stg_rd_wena  (stg_rd_wena),
            .stg_rd_waddr (stg_rd_waddr),
            .stg_data_rdy (stg_data_rdy),
            .sb_busy      (sb_busy_q),
            .src_sel      (src_sel[i*SEL_W +: SEL_W]),
            .src_stall    (src_stall_s[i])
        );
    end

    // A flush kills whatever sits in EX, so it never needs to wait.
    assign stall  = ex_valid & ~flush & (|src_stall_s);
    assign fire_s = ex_valid & ~stall;

    // Scoreboard next state: set beats clear, flush beats both, r0 never pending.
    always_comb begin
        set_mask_s = (fire_s & lat_issue) ? (ONE_HOT0 << lat_issue_rd) : '0;
        clr_mask_s = lat_done ? (ONE_HOT0 << lat_done_rd) : '0;
        if (flush) begin
            sb_busy_d = '0;
        end else begin
            sb_busy_d = ((sb_busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
        end
    end

    // Watchdog: saturating consecutive-stall run length and sticky timeout flag.
    always_comb begin
        stall_run_d      = stall ? sat_inc8(stall_run_q) : 8'd0;
        hazard_timeout_d = hazard_timeout_q
                         | (stall & (stall_run_q == WD_W'(STALL_TIMEOUT)));
    end

    // Scoreboard and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy_q        <= '0;
            stall_run_q      <= '0;
            hazard_timeout_q <= 1'b0;
        end else begin
            sb_busy_q        <= sb_busy_d;
            stall_run_q      <= stall_run_d;
            hazard_timeout_q <= hazard_timeout_d;
        end
    end

    assign sb_busy        = sb_busy_q;
    assign hazard_timeout = hazard_timeout_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_d, perf_stall_cnt_q;
    logic [31:0] perf_fwd_cnt_d,   perf_fwd_cnt_q;

    // Free-running wrap-around performance counters.
    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, stall};
        perf_fwd_cnt_d   = perf_fwd_cnt_q + {31'd0, fire_s & (|src_sel)};
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_q <= 32'd0;
            perf_fwd_cnt_q   <= 32'd0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_fwd_cnt_q   <= perf_fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_fwd_cnt   = perf_fwd_cnt_q;
`endif

endmodule
